// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI slave with an 8-bit full-duplex shift register, one-byte transmit buffer
// and receive holding register. All SPI pins are brought into the clk domain
// through SYNC_STAGES-flop synchronizers. Edge detection on the synchronized
// sck drives the shifting, so sck must be slow compared with clk. Each sck
// phase must last at least 4 clk periods.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   sck        SPI clock from the master (asynchronous)
//   ss_n       slave select, active low (asynchronous)
//   mosi       serial data from the master (asynchronous)
//   miso       serial data to the master (registered)
//   miso_oe    MISO pad enable, high while a transfer is active
//   cpol       clock polarity (idle level of sck)
//   cpha       clock phase (0: sample on leading edge, 1: on trailing edge)
//   lsbfe      1: LSB first, 0: MSB first (both directions)
//   tx_data    byte to transmit
//   tx_load    one-cycle strobe writing tx_data into the tx buffer
//   tx_empty   tx buffer empty
//   rx_data    last received byte
//   spif       byte-received flag
//   ovrf       overrun flag (byte received while spif was still set)
//   flag_clr   one-cycle strobe clearing spif and ovrf
// -----------------------------------------------------------------------------
module spi_slave #(
   parameter int SYNC_STAGES = 2   // 2..3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       ss_n,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic       cpol,
   input  logic       cpha,
   input  logic       lsbfe,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic       tx_empty,
   output logic [7:0] rx_data,
   output logic       spif,
   output logic       ovrf,
   input  logic       flag_clr
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // --------------------------------------------------------------------------
   // Input synchronizers and edge detection
   // --------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   // Marks which synchronizer stages hold real pin samples since reset.
   logic [SYNC_STAGES-1:0] sync_valid;
   logic                   sck_d;
   logic                   ss_d;
   // Set once ss_n has been seen high from the pin after reset; a select that
   // was already low when reset was released must not start a transfer.
   logic                   armed;

   logic sck_s;
   logic ss_s;
   logic mosi_s;

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // NOTE: clocked state is always assigned with <= so every flop samples the
   // pre-edge value of its neighbours; blocking here would turn the
   // synchronizer chain into a single flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync   <= '0;
         ss_sync    <= '1;
         mosi_sync  <= '0;
         sync_valid <= '0;
         sck_d      <= 1'b0;
         ss_d       <= 1'b1;
         armed      <= 1'b0;
      end else begin
         sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
         ss_sync    <= {ss_sync[SYNC_STAGES-2:0], ss_n};
         mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sync_valid <= {sync_valid[SYNC_STAGES-2:0], 1'b1};
         sck_d      <= sck_s;
         ss_d       <= ss_s;
         if ((&sync_valid) && ss_s) begin
            armed <= 1'b1;
         end
      end
   end

   logic sck_rise;
   logic sck_fall;
   logic lead_edge;
   logic trail_edge;
   logic sample_edge;
   logic shift_edge;
   logic ss_fall;

   assign sck_rise    = sck_s & ~sck_d;
   assign sck_fall    = ~sck_s & sck_d;
   // Leading edge leaves the idle (cpol) level, trailing edge returns to it.
   assign lead_edge   = cpol ? sck_fall : sck_rise;
   assign trail_edge  = cpol ? sck_rise : sck_fall;
   assign sample_edge = cpha ? trail_edge : lead_edge;
   assign shift_edge  = cpha ? lead_edge : trail_edge;
   assign ss_fall     = armed & ss_d & ~ss_s;

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   state_t     state_q;
   state_t     state_d;
   logic [2:0] bit_cnt;
   logic [7:0] shift_q;
   logic [7:0] tx_buf;
   logic       first_q;   // byte started last cycle: cpha=0 drives first bit

   // --------------------------------------------------------------------------
   // Next-state and datapath decode
   // --------------------------------------------------------------------------
   logic       byte_start;
   logic       byte_done;
   logic       do_sample;
   logic       miso_upd;
   logic [7:0] rx_byte;
   logic       out_bit;

   logic [2:0] bit_cnt_d;
   logic [7:0] shift_d;
   logic [7:0] tx_buf_d;
   logic       tx_empty_d;
   logic [7:0] rx_data_d;
   logic       spif_d;
   logic       ovrf_d;
   logic       miso_d;
   logic       spif_c;
   logic       ovrf_c;

   // Shift register contents after taking in the current mosi bit.
   assign rx_byte = lsbfe ? {mosi_s, shift_q[7:1]} : {shift_q[6:0], mosi_s};
   assign out_bit = lsbfe ? shift_q[0] : shift_q[7];

   // NOTE: every signal written here gets a default before any branch, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      byte_start = 1'b0;
      byte_done  = 1'b0;
      do_sample  = 1'b0;
      miso_upd   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d    = ACTIVE;
               byte_start = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_s) begin
               // Deselect (mid-byte or between bytes): drop the partial byte.
               state_d = IDLE;
            end else begin
               do_sample = sample_edge;
               if (sample_edge && (bit_cnt == 3'd7)) begin
                  byte_done  = 1'b1;
                  byte_start = 1'b1;
               end
               if (cpha) begin
                  miso_upd = shift_edge;
               end else begin
                  // The trailing edge after the 8th sample is skipped: the
                  // counter has wrapped and first_q presents the next byte.
                  miso_upd = first_q || (shift_edge && (bit_cnt != 3'd0));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bit_cnt_d  = bit_cnt;
      shift_d    = shift_q;
      tx_buf_d   = tx_buf;
      tx_empty_d = tx_empty;
      rx_data_d  = rx_data;
      miso_d     = miso;

      if (byte_start) begin
         shift_d    = tx_empty ? 8'h00 : tx_buf;
         tx_empty_d = 1'b1;
         bit_cnt_d  = 3'd0;
      end else if (do_sample) begin
         shift_d   = rx_byte;
         bit_cnt_d = bit_cnt + 3'd1;
      end
      if (state_d == IDLE) begin
         bit_cnt_d = 3'd0;
      end

      // A load coincident with a byte start wins for the buffer only; the
      // shift register above already took the old contents.
      if (tx_load) begin
         tx_buf_d   = tx_data;
         tx_empty_d = 1'b0;
      end

      if (miso_upd) begin
         miso_d = out_bit;
      end

      // flag_clr applies before a coincident byte completion is accounted.
      spif_c = spif & ~flag_clr;
      ovrf_c = ovrf & ~flag_clr;
      spif_d = spif_c;
      ovrf_d = ovrf_c;
      if (byte_done) begin
         if (!spif_c) begin
            rx_data_d = rx_byte;
            spif_d    = 1'b1;
         end else begin
            ovrf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         bit_cnt  <= 3'd0;
         shift_q  <= 8'h00;
         tx_buf   <= 8'h00;
         tx_empty <= 1'b1;
         rx_data  <= 8'h00;
         spif     <= 1'b0;
         ovrf     <= 1'b0;
         miso     <= 1'b0;
         miso_oe  <= 1'b0;
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         bit_cnt  <= bit_cnt_d;
         shift_q  <= shift_d;
         tx_buf   <= tx_buf_d;
         tx_empty <= tx_empty_d;
         rx_data  <= rx_data_d;
         spif     <= spif_d;
         ovrf     <= ovrf_d;
         miso     <= miso_d;
         miso_oe  <= (state_d == ACTIVE);
         first_q  <= byte_start;
      end
   end

endmodule
